// File: rtl/psa_search_engine.sv
// psa_search_engine
// Scans a window of a single-port BRAM for a stored pattern. Reports the first
// match, or counts every (overlapping) match, and can resume just past the last
// reported match. Every symbol compare is a FETCH/WAIT/CMP triple.
//
// Ports
//   CLK100MHZ, reset       clock, asynchronous active-high reset
//   pat_we/pat_idx/pat_din pattern register write (ignored while busy)
//   pat_len                pattern length, sampled on start/resume
//   base_addr, blk_len     search window, sampled on start
//   count_all              0 = stop at first match, 1 = count all
//   start, resume          commands (start wins)
//   mem_addr, mem_dout     BRAM port (1-cycle read latency)
//   busy, done, found, err status
//   found_addr, match_cnt  results
module psa_search_engine #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned MAX_PAT = 16,
   localparam int unsigned PIDX_W = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1,
   localparam int unsigned LEN_W  = ADDR_W + 1
) (
   input  logic              CLK100MHZ,
   input  logic              reset,
   input  logic              pat_we,
   input  logic [PIDX_W-1:0] pat_idx,
   input  logic [DATA_W-1:0] pat_din,
   input  logic [LEN_W-1:0]  pat_len,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  blk_len,
   input  logic              count_all,
   input  logic              start,
   input  logic              resume,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic              err,
   output logic [ADDR_W-1:0] found_addr,
   output logic [LEN_W-1:0]  match_cnt
);

   typedef enum logic [2:0] {StIdle, StFetch, StWait, StCmp, StDone} state_e;

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  cand_q, cand_d;
   logic [PIDX_W-1:0] j_q, j_d;
   logic [LEN_W-1:0]  last_q, last_d;
   logic [LEN_W-1:0]  plen_q, plen_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  blen_q, blen_d;
   logic              cnt_all_q, cnt_all_d;
   logic              abort_q, abort_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              done_q, done_d;
   logic              found_q, found_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] found_addr_q, found_addr_d;
   logic [LEN_W-1:0]  match_cnt_q, match_cnt_d;
   logic [DATA_W-1:0] pat_q [MAX_PAT];

   // Command acceptance and legality of the sampled lengths
   logic              acc_start, acc_resume;
   logic [ADDR_W-1:0] acc_base;
   logic [LEN_W-1:0]  acc_blen, acc_cand, acc_last;
   logic              len_bad, too_long, past_end;

   assign acc_start  = start && (state_q == StIdle || state_q == StDone);
   assign acc_resume = resume && !start && (state_q == StDone) && found_q && !cnt_all_q;
   assign acc_base   = acc_start ? base_addr : base_q;
   assign acc_blen   = acc_start ? blk_len : blen_q;
   // Resume restarts one candidate past the last reported match.
   assign acc_cand   = acc_start ? '0 : LEN_W'(found_addr_q - base_q) + LEN_W'(1);
   assign len_bad    = (pat_len == '0) || (pat_len > LEN_W'(MAX_PAT));
   assign too_long   = pat_len > acc_blen;
   assign acc_last   = acc_blen - pat_len;
   assign past_end   = acc_cand > acc_last;

   // Compare-stage helpers
   logic              sym_eq, last_sym, last_cand, finish;
   logic [ADDR_W-1:0] cand_addr;

   assign sym_eq    = mem_dout == pat_q[j_q];
   assign last_sym  = LEN_W'(j_q) == (plen_q - LEN_W'(1));
   assign last_cand = cand_q == last_q;
   assign cand_addr = base_q + cand_q[ADDR_W-1:0];

   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      j_d          = j_q;
      last_d       = last_q;
      plen_d       = plen_q;
      base_d       = base_q;
      blen_d       = blen_q;
      cnt_all_d    = cnt_all_q;
      abort_d      = abort_q;
      mem_addr_d   = mem_addr_q;
      done_d       = done_q;
      found_d      = found_q;
      err_d        = err_q;
      found_addr_d = found_addr_q;
      match_cnt_d  = match_cnt_q;
      finish       = 1'b0;

      case (state_q)
         StIdle, StDone: begin
            if (acc_start || acc_resume) begin
               state_d = StFetch;
               base_d  = acc_base;
               blen_d  = acc_blen;
               plen_d  = pat_len;
               cand_d  = acc_cand;
               last_d  = acc_last;
               j_d     = '0;
               done_d  = 1'b0;
               err_d   = len_bad;
               // Illegal or empty searches pass through FETCH without reading.
               abort_d = len_bad || too_long || past_end;
               if (acc_start) begin
                  cnt_all_d   = count_all;
                  match_cnt_d = '0;
                  found_d     = 1'b0;
               end
            end
         end
         StFetch: begin
            if (abort_q) begin
               state_d = StDone;
               done_d  = 1'b1;
               found_d = !err_q && (match_cnt_q != '0);
            end else begin
               mem_addr_d = cand_addr + ADDR_W'(j_q);
               state_d    = StWait;
            end
         end
         StWait: state_d = StCmp;
         StCmp: begin
            if (sym_eq && !last_sym) begin
               j_d     = j_q + PIDX_W'(1);
               state_d = StFetch;
            end else begin
               j_d = '0;
               if (sym_eq) begin
                  match_cnt_d = match_cnt_q + LEN_W'(1);
                  if (!cnt_all_q) begin
                     found_addr_d = cand_addr;
                     finish       = 1'b1;
                  end else begin
                     if (match_cnt_q == '0) found_addr_d = cand_addr;
                     finish = last_cand;
                  end
               end else begin
                  finish = last_cand;
               end
               if (finish) begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  found_d = match_cnt_d != '0;
               end else begin
                  cand_d  = cand_q + LEN_W'(1);
                  state_d = StFetch;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         cand_q       <= '0;
         j_q          <= '0;
         last_q       <= '0;
         plen_q       <= '0;
         base_q       <= '0;
         blen_q       <= '0;
         cnt_all_q    <= 1'b0;
         abort_q      <= 1'b0;
         mem_addr_q   <= '0;
         done_q       <= 1'b0;
         found_q      <= 1'b0;
         err_q        <= 1'b0;
         found_addr_q <= '0;
         match_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         cand_q       <= cand_d;
         j_q          <= j_d;
         last_q       <= last_d;
         plen_q       <= plen_d;
         base_q       <= base_d;
         blen_q       <= blen_d;
         cnt_all_q    <= cnt_all_d;
         abort_q      <= abort_d;
         mem_addr_q   <= mem_addr_d;
         done_q       <= done_d;
         found_q      <= found_d;
         err_q        <= err_d;
         found_addr_q <= found_addr_d;
         match_cnt_q  <= match_cnt_d;
      end
   end

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MAX_PAT; i++) pat_q[i] <= '0;
      end else if (pat_we && !busy) begin
         pat_q[pat_idx] <= pat_din;
      end
   end

   assign busy       = (state_q == StFetch) || (state_q == StWait) || (state_q == StCmp);
   assign mem_addr   = mem_addr_q;
   assign done       = done_q;
   assign found      = found_q;
   assign err        = err_q;
   assign found_addr = found_addr_q;
   assign match_cnt  = match_cnt_q;

endmodule

// File: tb/tb_psa_search_engine.sv
// Bench for psa_search_engine: directed scenarios, a search-level model that
// predicts completion time and results, and a per-cycle compare process.
module tb_psa_search_engine;

   logic       CLK100MHZ = 1'b0;
   logic       reset;
   logic       pat_we;
   logic [3:0] pat_idx;
   logic [7:0] pat_din;
   logic [8:0] pat_len;
   logic [7:0] base_addr;
   logic [8:0] blk_len;
   logic       count_all, start, resume;
   logic [7:0] mem_addr, mem_dout;
   logic       busy, done, found, err;
   logic [7:0] found_addr;
   logic [8:0] match_cnt;

   always #5 CLK100MHZ = ~CLK100MHZ;

   psa_search_engine dut (
      .CLK100MHZ (CLK100MHZ),
      .reset     (reset),
      .pat_we    (pat_we),
      .pat_idx   (pat_idx),
      .pat_din   (pat_din),
      .pat_len   (pat_len),
      .base_addr (base_addr),
      .blk_len   (blk_len),
      .count_all (count_all),
      .start     (start),
      .resume    (resume),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .busy      (busy),
      .done      (done),
      .found     (found),
      .err       (err),
      .found_addr(found_addr),
      .match_cnt (match_cnt)
   );

   // BRAM with one cycle of read latency
   logic [7:0] mem [256];
   always @(posedge CLK100MHZ) mem_dout <= mem[mem_addr];

   int cyc = 0;
   always @(posedge CLK100MHZ) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Search-level model
   logic [7:0] m_pat [16];
   int m_base, m_blen, m_plen, m_fa, m_cnt, m_total;
   bit m_cnt_all, m_found, m_err;
   int e0;
   bit mdl_valid = 1'b0;

   task automatic model_run(input bit is_res);
      int c0, last, sum;
      bit stop;
      sum    = 0;
      m_plen = int'(pat_len);
      if (!is_res) begin
         m_base    = int'(base_addr);
         m_blen    = int'(blk_len);
         m_cnt_all = count_all;
         m_cnt     = 0;
         c0        = 0;
      end else begin
         c0 = ((m_fa - m_base) & 255) + 1;
      end
      m_err = (m_plen == 0) || (m_plen > 16);
      if (m_err) begin
         m_total = 1;
         m_found = 1'b0;
         return;
      end
      last = m_blen - m_plen;
      if (m_plen > m_blen || c0 > last) begin
         m_total = 1;
         m_found = (m_cnt != 0);
         return;
      end
      stop = 1'b0;
      for (int c = c0; c <= last && !stop; c++) begin
         int n;
         n = 0;
         while (n < m_plen && mem[(m_base + c + n) & 255] == m_pat[n]) n++;
         if (n == m_plen) begin
            sum += 3 * m_plen;
            m_cnt++;
            if (!m_cnt_all) begin
               m_fa = (m_base + c) & 255;
               stop = 1'b1;
            end else if (m_cnt == 1) begin
               m_fa = (m_base + c) & 255;
            end
         end else begin
            sum += 3 * (n + 1);
         end
      end
      m_total = sum;
      m_found = (m_cnt != 0);
   endtask

   // Per-cycle comparison against the model
   always @(negedge CLK100MHZ) begin
      int k;
      if (mdl_valid) begin
         k = cyc - e0;
         chk("busy", busy, k < m_total);
         chk("done", done, k >= m_total);
         if (k >= m_total) begin
            chk("found", found, m_found);
            chk("err", err, m_err);
            chk("match_cnt", match_cnt, m_cnt);
            if (m_found) chk("found_addr", found_addr, m_fa);
         end
      end
   end

   // Address-bus observation
   int chg_cnt = 0;
   int wrap_cnt = 0;
   logic [7:0] prev_addr = 8'h00;
   always @(negedge CLK100MHZ) begin
      if (mem_addr != prev_addr) chg_cnt <= chg_cnt + 1;
      if (prev_addr == 8'hFF && mem_addr == 8'h00) wrap_cnt <= wrap_cnt + 1;
      prev_addr <= mem_addr;
   end

   task automatic accept(input bit is_res);
      @(negedge CLK100MHZ);
      if (is_res) resume = 1'b1;
      else start = 1'b1;
      @(posedge CLK100MHZ);
      #1;
      start  = 1'b0;
      resume = 1'b0;
      model_run(is_res);
      e0 = cyc;
      mdl_valid = 1'b1;
   endtask

   task automatic wait_done(input string name);
      repeat (m_total + 1) @(posedge CLK100MHZ);
      #1;
      chk(name, done, 1'b1);
   endtask

   task automatic write_pat(input int idx, input logic [7:0] d, input bit taken);
      @(negedge CLK100MHZ);
      pat_we  = 1'b1;
      pat_idx = idx[3:0];
      pat_din = d;
      @(posedge CLK100MHZ);
      #1;
      pat_we = 1'b0;
      if (taken) m_pat[idx] = d;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_found"}, found, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_found_addr"}, found_addr, 0);
      chk({tag, "_match_cnt"}, match_cnt, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap, wsnap;
      reset = 1'b1; pat_we = 1'b0; pat_idx = '0; pat_din = '0; pat_len = '0;
      base_addr = '0; blk_len = '0; count_all = 1'b0; start = 1'b0; resume = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h11;
      mem[8'h10] = 8'hAB; mem[8'h11] = 8'hCD; mem[8'h12] = 8'hEF;
      for (int i = 8'h20; i <= 8'h23; i++) mem[i] = 8'hAA;
      mem[8'h30] = 8'h00; mem[8'h31] = 8'h00;
      mem[8'hFF] = 8'h5A; mem[8'h00] = 8'hA5;
      for (int i = 0; i < 16; i++) m_pat[i] = 8'h00;
      m_fa = 0; m_cnt = 0;
      #12;
      chk_all_zero("rst");
      @(negedge CLK100MHZ);
      reset = 1'b0;

      // First match of a 3-symbol pattern
      write_pat(0, 8'hAB, 1'b1);
      write_pat(1, 8'hCD, 1'b1);
      write_pat(2, 8'hEF, 1'b1);
      pat_len = 9'd3; base_addr = 8'h00; blk_len = 9'h40; count_all = 1'b0;
      accept(1'b0);
      chk("t1_model_total", m_total, 57);
      wait_done("t1_done");
      chk("t1_found_addr", found_addr, 8'h10);
      chk("t1_match_cnt", match_cnt, 1);
      chk("t1_found", found, 1);
      chk("t1_err", err, 0);

      // No match, then a resume that must be ignored
      base_addr = 8'h40; blk_len = 9'h10;
      accept(1'b0);
      chk("nm_model_total", m_total, 42);
      wait_done("nm_done");
      chk("nm_found", found, 0);
      @(negedge CLK100MHZ); resume = 1'b1;
      @(posedge CLK100MHZ); #1; resume = 1'b0;
      chk("nm_resume_busy", busy, 0);
      chk("nm_resume_done", done, 1);

      // Overlapping count-all; also a pattern write while busy is dropped
      write_pat(0, 8'hAA, 1'b1);
      write_pat(1, 8'hAA, 1'b1);
      pat_len = 9'd2; base_addr = 8'h20; blk_len = 9'd4; count_all = 1'b1;
      accept(1'b0);
      repeat (5) @(posedge CLK100MHZ);
      #1 chk("t2_cnt_at_5", match_cnt, 0);
      @(posedge CLK100MHZ);
      #1 chk("t2_cnt_at_6", match_cnt, 1);
      write_pat(0, 8'h00, 1'b0);
      wait_done("t2_done");
      chk("t2_model_total", m_total, 18);
      chk("t2_match_cnt", match_cnt, 3);
      chk("t2_found_addr", found_addr, 8'h20);

      // First-match with resumes
      count_all = 1'b0;
      accept(1'b0);
      wait_done("t3_done0");
      chk("t3_fa0", found_addr, 8'h20);
      accept(1'b1);
      wait_done("t3_done1");
      chk("t3_fa1", found_addr, 8'h21);
      chk("t3_cnt1", match_cnt, 2);
      accept(1'b1);
      wait_done("t3_done2");
      chk("t3_fa2", found_addr, 8'h22);
      chk("t3_cnt2", match_cnt, 3);
      snap = chg_cnt;
      accept(1'b1);
      wait_done("t3_done3");
      chk("t3_model_total3", m_total, 1);
      chk("t3_fa3", found_addr, 8'h22);
      chk("t3_cnt3", match_cnt, 3);
      chk("t3_no_reads", chg_cnt, snap);

      // Window wrapping past the top of memory
      write_pat(0, 8'h5A, 1'b1);
      write_pat(1, 8'hA5, 1'b1);
      base_addr = 8'hFE; blk_len = 9'd4;
      wsnap = wrap_cnt;
      accept(1'b0);
      wait_done("t4_done");
      chk("t4_model_total", m_total, 9);
      chk("t4_found_addr", found_addr, 8'hFF);
      chk("t4_wrap_seen", (wrap_cnt > wsnap), 1);

      // Illegal and oversized lengths
      pat_len = 9'd0;
      snap = chg_cnt;
      accept(1'b0);
      chk("t5_busy_e0", busy, 1);
      chk("t5_done_e0", done, 0);
      wait_done("t5_done");
      chk("t5_err", err, 1);
      chk("t5_model_total", m_total, 1);
      pat_len = 9'd17;
      accept(1'b0);
      wait_done("t5b_done");
      chk("t5b_err", err, 1);
      pat_len = 9'd5; blk_len = 9'd4;
      accept(1'b0);
      chk("t5c_done_e0", done, 0);
      wait_done("t5c_done");
      chk("t5c_err", err, 0);
      chk("t5c_found", found, 0);
      chk("t5c_no_reads", chg_cnt, snap);

      // Reset during WAIT, then a fresh search with cleared pattern registers
      pat_len = 9'd3; base_addr = 8'h00; blk_len = 9'h40;
      accept(1'b0);
      @(posedge CLK100MHZ);
      mdl_valid = 1'b0;
      #2 reset = 1'b1;
      #1 chk_all_zero("midrst");
      for (int i = 0; i < 16; i++) m_pat[i] = 8'h00;
      m_fa = 0; m_cnt = 0; m_found = 1'b0;
      @(negedge CLK100MHZ);
      reset = 1'b0;
      pat_len = 9'd2; base_addr = 8'h28; blk_len = 9'h10; count_all = 1'b0;
      accept(1'b0);
      chk("t6_model_total", m_total, 30);
      wait_done("t6_done");
      chk("t6_found_addr", found_addr, 8'h30);
      chk("t6_found", found, 1);

      mdl_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
